boa_mem_responder: RTL and testbench
====================================

# boa_mem_responder

Responder (memory side) of the `boa_mem_bus` data/instruction memory protocol. It backs a word-addressed, byte-writable on-chip RAM window and answers CPU load/store requests with an optional fixed number of wait states. It sits between the CPU's memory bus port and the SoC fabric. The same block is instantiated once per RAM region (data RAM, scratchpad).

## Interface
Parameters:
- `DEPTH_LOG2`, default 12: RAM depth is 2^DEPTH_LOG2 32-bit words.
- `BASE`, default 32'h0000_0000: window base address, aligned to 4·2^DEPTH_LOG2.
- `WAIT`, default 0: wait states per accepted hit, range 0..15.

Ports:
- `clk`  in  1: CPU clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `bus`  modport `boa_mem_bus.MEM`: the responder end of the bus. It carries these signals:
  - `bus.re`  in  1: read request.
  - `bus.we`  in  4: per-byte-lane write enables.
  - `bus.addr[31:2]`  in  30: word address.
  - `bus.wdata`  in  32: lane-replicated write data.
  - `bus.ready`  out  1: request accepted this cycle.
  - `bus.rdata`  out  32: read data.

## Operation
- Request present: `req = re | (|we)`.
- Hit: `addr[31:2+DEPTH_LOG2] == BASE[31:2+DEPTH_LOG2]`.
- Index: `idx = addr[1+DEPTH_LOG2:2]`.
- Acceptance: the rising edge on which `req && ready` holds.
  - Writes: for each i with `we[i]`, set `mem[idx][8i+7:8i] <= wdata[8i+7:8i]`.
  - Reads: `rdata_q <= mem[idx]`.
- `re` and `we` together: the write is performed, and `rdata` returns the old (pre-write) word.
- Miss: accepted with zero wait states regardless of `WAIT`. Writes are dropped and `rdata_q <= 0`.
- `bus.rdata = rdata_q`. It holds its value until the next accepted read, and is unaffected by writes, misses without `re`, and idle cycles.
- The responder never inspects alignment; the initiator has already gated illegal lanes.
- Wait-state FSM (hits only):
  - IDLE:
    - `ready = !(req && hit && WAIT!=0)`.
    - On `req && hit && WAIT!=0`: go to BUSY with `cnt <= WAIT-1`.
  - BUSY:
    - `ready = (cnt==0)`.
    - If `!req`: the request was withdrawn. Go to IDLE with no side effects.
    - Else if `cnt!=0`: `cnt <= cnt-1`.
    - Else: accept and go to IDLE.
- Every accepted hit costs exactly WAIT stall cycles, including back-to-back requests.
- `ready` is combinational from `req`, `hit` and FSM state, and is high whenever there is no request.

## Timing
- Reset (`rst` low, asynchronous):
  - State is IDLE, `cnt = 0`, `rdata_q = 32'h0`.
  - `bus.ready` therefore reads 1 while idle.
  - RAM contents are not reset.
- Zero-wait hit: request in cycle N with `ready=1`, and data appears on `rdata` in cycle N+1. This matches the initiator, which latches the byte offset in cycle N and extracts it in N+1.
- WAIT=k hit:
  - `ready` is low in cycles N..N+k-1 and high in N+k.
  - `rdata` is valid in N+k+1.
- The initiator holds `addr`, `we`, `wdata` and `re` stable while `ready` is low. The values sampled at the acceptance edge are the ones that take effect.
- If the request is withdrawn mid-wait (pipeline clear), no write occurs and `rdata` is unchanged. A new request in the cycle after withdrawal starts a fresh count from IDLE.
- Reset asserted mid-wait: the transaction is abandoned immediately with no write.

## Configuration
- `BOA_MEM_RESP_WAIT_EN` defined: the `WAIT` parameter and the BUSY state/counter are built as described.
- Not defined:
  - The FSM and counter are compiled out and `WAIT` is ignored.
  - `ready` is tied to 1 and every request is accepted in its first cycle.
  - All other behaviour is identical.

## Test plan
- WAIT=0, macro on:
  - Write `addr=0x10`, `we=4'b1111`, `wdata=0xDEADBEEF`.
  - Then read `0x10`. Required: `ready` stays 1 throughout, and `rdata=0xDEADBEEF` in the cycle after the read.
- Byte lanes:
  - Write `0x11223344` to `0x20`.
  - Then `we=4'b0100` with `wdata=0xAAAAAAAA`.
  - Then read `0x20`. Required: `rdata=0x11AA3344`.
- WAIT=3, macro on, read hit:
  - Required: `ready` low for exactly 3 cycles, then high for 1 cycle, and `rdata` valid on the following cycle.
  - A back-to-back second read also stalls 3 cycles.
- WAIT=3, withdrawal:
  - Write request, drop `req` after 1 stall cycle, then read the same word.
  - Required: old contents returned, so the write was not performed.
- Miss:
  - Set `BASE=0x1000_0000` and write `0x0000_0040`.
  - Required: `ready=1` immediately, no RAM change, and a read of the miss address returns `rdata=0`.
- Reset:
  - Assert `rst` low during a WAIT=3 stall.
  - Required: `ready=1`, `rdata=0` asynchronously, and a previously written word is still readable after release.

Source files
------------

// File: rtl/boa_mem_responder_if.sv
// boa_mem_bus: CPU-to-memory load/store bus.
// The CPU port drives requests; the MEM port accepts them and returns read data.
interface boa_mem_bus;
   logic        re;
   logic [3:0]  we;
   logic [31:2] addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;
   modport MEM (input re, we, addr, wdata, output ready, rdata);
   modport CPU (output re, we, addr, wdata, input ready, rdata);
endinterface

// File: rtl/boa_mem_responder.sv
// boa_mem_responder: byte-writable RAM window behind boa_mem_bus.
// Optional wait states are built with BOA_MEM_RESP_WAIT_EN.
module boa_mem_responder #(
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [31:0] BASE       = 32'h0000_0000,
   parameter int          WAIT       = 0
) (
   input logic  clk,
   input logic  rst,
   boa_mem_bus.MEM bus
);
   localparam int HI = 2 + DEPTH_LOG2;
   if (WAIT < 0 || WAIT > 15) begin : g_wait_range
      $error("boa_mem_responder: WAIT must be 0..15");
   end
   logic [31:0]           mem [2**DEPTH_LOG2];
   logic [31:0]           rdata_q;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  req, hit, ready, accept;
   assign req    = bus.re | (|bus.we);
   assign hit    = bus.addr[31:HI] == BASE[31:HI];
   assign idx    = bus.addr[HI-1:2];
   assign accept = req && ready;
`ifdef BOA_MEM_RESP_WAIT_EN
   typedef enum logic {IDLE, BUSY} state_t;
   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   // misses never enter BUSY; a withdrawn request leaves BUSY without side effects
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ready    = 1'b1;
      if (state == IDLE) begin
         ready = !(req && hit && WAIT != 0);
         if (!ready) begin
            state_nx = BUSY;
            cnt_nx   = 4'(WAIT - 1);
         end
      end else begin
         ready = !req || cnt == 4'd0;
         if (!req) state_nx = IDLE;
         else if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
         else state_nx = IDLE;
      end
   end
`else
   assign ready = 1'b1;
`endif
   always_ff @(posedge clk)
      if (accept && hit)
         for (int i = 0; i < 4; i++)
            if (bus.we[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
   // read-with-write returns the pre-write word since mem updates on the same edge
   always_ff @(posedge clk or negedge rst)
      if (!rst) rdata_q <= '0;
      else if (accept && bus.re) rdata_q <= hit ? mem[idx] : '0;
   assign bus.ready = ready;
   assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_boa_mem_responder.sv
// tb_boa_mem_responder: directed checks of a zero-wait and a WAIT=3 responder.
// Stall expectations follow whether BOA_MEM_RESP_WAIT_EN is built in.
module tb_boa_mem_responder;
`ifdef BOA_MEM_RESP_WAIT_EN
   localparam int S = 3;
`else
   localparam int S = 0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vec = 0;
   int   bad = 0;
   int   st;
   boa_mem_bus b0 ();
   boa_mem_bus b3 ();
   boa_mem_responder #(.DEPTH_LOG2(8), .BASE(32'h0000_0000), .WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   boa_mem_responder #(.DEPTH_LOG2(8), .BASE(32'h1000_0000), .WAIT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic set0(input logic re, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      b0.re = re; b0.we = we; b0.addr = a[31:2]; b0.wdata = d;
   endtask
   task automatic set3(input logic re, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      b3.re = re; b3.we = we; b3.addr = a[31:2]; b3.wdata = d;
   endtask
   // drive a request on dut3, count low-ready cycles, return just after the accepting edge
   task automatic xact3(input logic re, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d, output int stalls);
      set3(re, we, a, d);
      stalls = 0;
      #1;
      while (!b3.ready && stalls < 20) begin
         tick;
         #1;
         stalls++;
      end
      tick;
   endtask
   initial begin
      set0(0, 4'h0, 32'h0, 32'h0);
      set3(0, 4'h0, 32'h0, 32'h0);
      #3;
      chk("reset_ready0", 32'(b0.ready), 32'd1);
      chk("reset_rdata0", b0.rdata, 32'h0);
      chk("reset_ready3", 32'(b3.ready), 32'd1);
      chk("reset_rdata3", b3.rdata, 32'h0);
      tick;
      rst = 1'b1;
      tick;
      set0(0, 4'hF, 32'h10, 32'hDEADBEEF);
      #1 chk("w0_write_ready", 32'(b0.ready), 32'd1);
      tick;
      chk("w0_rdata_after_write", b0.rdata, 32'h0);
      set0(1, 4'h0, 32'h10, 32'h0);
      #1 chk("w0_read_ready", 32'(b0.ready), 32'd1);
      tick;
      chk("w0_read_data", b0.rdata, 32'hDEADBEEF);
      set0(0, 4'hF, 32'h20, 32'h11223344);
      tick;
      set0(0, 4'b0100, 32'h20, 32'hAAAAAAAA);
      tick;
      chk("lane_rdata_held", b0.rdata, 32'hDEADBEEF);
      set0(1, 4'h0, 32'h20, 32'h0);
      tick;
      chk("lane_read", b0.rdata, 32'h11AA3344);
      set0(1, 4'b0001, 32'h20, 32'h000000FF);
      tick;
      chk("rw_old_word", b0.rdata, 32'h11AA3344);
      set0(1, 4'h0, 32'h20, 32'h0);
      tick;
      chk("rw_new_word", b0.rdata, 32'h11AA33FF);
      set0(0, 4'h0, 32'h0, 32'h0);
      tick;
      chk("idle_rdata_held", b0.rdata, 32'h11AA33FF);
      xact3(0, 4'hF, 32'h1000_0010, 32'hCAFEF00D, st);
      chk("w3_write_stalls", 32'(st), 32'(S));
      xact3(0, 4'hF, 32'h1000_0014, 32'h0BADC0DE, st);
      chk("w3_write2_stalls", 32'(st), 32'(S));
      xact3(1, 4'h0, 32'h1000_0010, 32'h0, st);
      chk("w3_read_stalls", 32'(st), 32'(S));
      chk("w3_read_data", b3.rdata, 32'hCAFEF00D);
      xact3(1, 4'h0, 32'h1000_0014, 32'h0, st);
      chk("w3_b2b_stalls", 32'(st), 32'(S));
      chk("w3_b2b_data", b3.rdata, 32'h0BADC0DE);
      set3(0, 4'hF, 32'h1000_0010, 32'h12345678);
      #1 chk("wd_ready_first", 32'(b3.ready), S == 0 ? 32'd1 : 32'd0);
      tick;
      set3(0, 4'h0, 32'h1000_0010, 32'h0);
      #1 chk("wd_ready_idle", 32'(b3.ready), 32'd1);
      tick;
      chk("wd_rdata_unchanged", b3.rdata, 32'h0BADC0DE);
      xact3(1, 4'h0, 32'h1000_0010, 32'h0, st);
      chk("wd_read_stalls", 32'(st), 32'(S));
      chk("wd_read_data", b3.rdata, S == 0 ? 32'h12345678 : 32'hCAFEF00D);
      xact3(0, 4'hF, 32'h0000_0040, 32'hFFFFFFFF, st);
      chk("miss_write_stalls", 32'(st), 32'd0);
      xact3(0, 4'hF, 32'h0000_0010, 32'hFFFFFFFF, st);
      chk("miss_alias_stalls", 32'(st), 32'd0);
      chk("miss_rdata_held", b3.rdata, S == 0 ? 32'h12345678 : 32'hCAFEF00D);
      xact3(1, 4'h0, 32'h0000_0040, 32'h0, st);
      chk("miss_read_stalls", 32'(st), 32'd0);
      chk("miss_read_data", b3.rdata, 32'h0);
      xact3(1, 4'h0, 32'h1000_0010, 32'h0, st);
      chk("miss_no_ram_change", b3.rdata, S == 0 ? 32'h12345678 : 32'hCAFEF00D);
      set3(0, 4'hF, 32'h1000_0014, 32'h55555555);
      tick;
      set3(0, 4'h0, 32'h0, 32'h0);
      rst = 1'b0;
      #1;
      chk("rst_ready3", 32'(b3.ready), 32'd1);
      chk("rst_rdata3", b3.rdata, 32'h0);
      chk("rst_rdata0", b0.rdata, 32'h0);
      tick;
      rst = 1'b1;
      tick;
      xact3(1, 4'h0, 32'h1000_0014, 32'h0, st);
      chk("rst_read_stalls", 32'(st), 32'(S));
      chk("rst_abandoned_write", b3.rdata, S == 0 ? 32'h55555555 : 32'h0BADC0DE);
      set3(0, 4'h0, 32'h0, 32'h0);
      set0(1, 4'h0, 32'h10, 32'h0);
      tick;
      chk("rst_ram_kept", b0.rdata, 32'hDEADBEEF);
      set0(0, 4'h0, 32'h0, 32'h0);
      tick;
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
